// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: queues set/reset/hold commands in a small FIFO and plays them out to a
// downstream SR flip-flop, one command per three cycles (IDLE -> DRIVE -> CHECK). During
// CHECK the fed-back q is compared against the value the last command should have left,
// and any disagreement raises a sticky mismatch flag.
//
// Ports:
//   clk, rstn          clock; asynchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_op 00 hold, 01 reset, 10 set, 11 illegal
//   q_in               q fed back from the downstream flip-flop
//   mism_clr           synchronous clear of mismatch (a same-cycle new mismatch wins)
//   s, r               registered set/reset drives, each high for the single DRIVE cycle
//   busy               FSM not idle or FIFO not empty
//   err_illegal        one-cycle pulse after an illegal command is rejected
//   mismatch           sticky compare-failure flag
//   count              FIFO occupancy
module sr_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic                     q_in,
  input  logic                     mism_clr,
  output logic                     s,
  output logic                     r,
  output logic                     busy,
  output logic                     err_illegal,
  output logic                     mismatch,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e          state_q, state_d;
  logic [1:0]      fifo_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            err_q, err_d;
  logic            mism_q, mism_d;
  logic            exp_q, exp_d;
  logic            push, pop;

  // Ready depends on registered occupancy only, so a same-cycle pop cannot raise it.
  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready && (cmd_op != 2'b11);
  assign pop       = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    exp_d   = exp_q;
    mism_d  = mism_q;
    err_d   = cmd_valid && cmd_ready && (cmd_op == 2'b11);

    // Pointers wrap naturally: DEPTH is a power of two and they are AW bits wide.
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (mism_clr) begin
      mism_d = 1'b0;
    end
    // Evaluated after the clear so a new mismatch wins over mism_clr.
    if ((state_q == StCheck) && (q_in != exp_q)) begin
      mism_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (pop) begin
          op_d    = fifo_q[rptr_q];
          s_d     = (fifo_q[rptr_q] == 2'b10);
          r_d     = (fifo_q[rptr_q] == 2'b01);
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (op_q == 2'b01) begin
          exp_d = 1'b0;
        end else if (op_q == 2'b10) begin
          exp_d = 1'b1;
        end
        state_d = StCheck;
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      op_q    <= 2'b00;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= 1'b0;
      mism_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      err_q   <= err_d;
      mism_q  <= mism_d;
      exp_q   <= exp_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= cmd_op;
    end
  end

  assign s           = s_q;
  assign r           = r_q;
  assign busy        = (state_q != StIdle) || (count_q != '0);
  assign err_illegal = err_q;
  assign mismatch    = mism_q;
  assign count       = count_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: a vector table of single commands, hand-written multi-cycle
// sequences, a model of the downstream SR flip-flop, and a scoreboard of expected s/r
// pulses that a negedge monitor pops in order.
module tb_sr_cmd_sequencer;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       q_in;
  logic       mism_clr = 1'b0;
  logic       s, r, busy, err_illegal, mismatch;
  logic [2:0] count;

  logic q_ff;
  logic q_force_en = 1'b0;
  logic q_force_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int err_cycles = 0;
  int last_s_cyc = 0;
  int last_r_cyc = 0;
  int max_count = 0;
  logic ready_low_seen = 1'b0;
  logic [1:0] sb[$];

  typedef struct {
    logic [1:0] op;
    logic       force_en;
    logic       force_val;
    logic       exp_err;
    logic       exp_mism;
    logic       exp_q;
  } vec_t;

  sr_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .q_in        (q_in),
    .mism_clr    (mism_clr),
    .s           (s),
    .r           (r),
    .busy        (busy),
    .err_illegal (err_illegal),
    .mismatch    (mismatch),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Downstream SR flip-flop.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) q_ff <= 1'b0;
    else if (s) q_ff <= 1'b1;
    else if (r) q_ff <= 1'b0;
  end

  assign q_in = q_force_en ? q_force_val : q_ff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(cmd_ready), 32'd1);
    if (cmd_ready && (op == 2'b10 || op == 2'b01)) sb.push_back(op);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic monitor();
    logic       ps = 1'b0;
    logic       pr = 1'b0;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      check("ready_vs_count", 32'(cmd_ready), 32'(count < 3'(DEPTH)));
      if (int'(count) > max_count) max_count = int'(count);
      if (!cmd_ready) ready_low_seen = 1'b1;
      if (rstn) begin
        if (err_illegal) err_cycles++;
        if (s || r) begin
          pulses++;
          check("s_r_exclusive", 32'(s && r), 32'd0);
          check("pulse_width", 32'((s && ps) || (r && pr)), 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got s=%0b r=%0b expected none", s, r);
          end else begin
            e = sb.pop_front();
            check("pulse_order", 32'({s, r}), 32'(e));
          end
          if (s) last_s_cyc = cyc;
          if (r) last_r_cyc = cyc;
        end
      end
      ps = s;
      pr = r;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[8];
    logic [1:0] ops35[7];
    logic [1:0] ops38[10];
    int         e0;
    int         p0;

    vecs[0] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ops35 = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
    ops38 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};

    fork
      monitor();
    join_none

    // Reset state.
    tick();
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_s", 32'(s), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    rstn = 1'b1;

    // Single-command vectors.
    for (int i = 0; i < 8; i++) begin
      q_force_en  = vecs[i].force_en;
      q_force_val = vecs[i].force_val;
      e0 = err_cycles;
      send(vecs[i].op);
      wait_idle();
      tick();
      tick();
      check("vec_err", 32'(err_cycles - e0), 32'(vecs[i].exp_err));
      check("vec_mismatch", 32'(mismatch), 32'(vecs[i].exp_mism));
      check("vec_count", 32'(count), 32'd0);
      check("vec_q", 32'(q_ff), 32'(vecs[i].exp_q));
      q_force_en = 1'b0;
      mism_clr   = 1'b1;
      tick();
      mism_clr   = 1'b0;
    end

    // Mismatch: set wins over a same-cycle clear, sticky across commands, then clears.
    q_force_en  = 1'b1;
    q_force_val = 1'b0;
    send(2'b10);
    tick();
    tick();
    check("mism_before_set", 32'(mismatch), 32'd0);
    mism_clr = 1'b1;
    tick();
    mism_clr   = 1'b0;
    q_force_en = 1'b0;
    check("mism_set_wins", 32'(mismatch), 32'd1);
    send(2'b01);
    wait_idle();
    check("mism_sticky", 32'(mismatch), 32'd1);
    mism_clr = 1'b1;
    tick();
    mism_clr = 1'b0;
    check("mism_cleared", 32'(mismatch), 32'd0);

    // Set then reset: r follows s by three cycles, q goes 1 then 0.
    send(2'b10);
    send(2'b01);
    tick();
    check("sr_q_high", 32'(q_ff), 32'd1);
    wait_idle();
    tick();
    check("sr_spacing", 32'(last_r_cyc - last_s_cyc), 32'd3);
    check("sr_q_low", 32'(q_ff), 32'd0);
    check("sr_mismatch", 32'(mismatch), 32'd0);

    // Illegal command.
    e0 = err_cycles;
    send(2'b11);
    check("ill_count", 32'(count), 32'd0);
    check("ill_err_high", 32'(err_illegal), 32'd1);
    tick();
    check("ill_err_low", 32'(err_illegal), 32'd0);
    tick();
    check("ill_err_cycles", 32'(err_cycles - e0), 32'd1);

    // Back-to-back flood: ready drops at count = DEPTH, all run in order.
    max_count      = 0;
    ready_low_seen = 1'b0;
    for (int i = 0; i < 7; i++) send(ops35[i]);
    wait_idle();
    tick();
    check("flood_max_count", 32'(max_count), 32'(DEPTH));
    check("flood_ready_low", 32'(ready_low_seen), 32'd1);
    check("flood_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during DRIVE of a set with two entries queued.
    send(2'b00);
    send(2'b10);
    send(2'b01);
    send(2'b10);
    tick();
    check("abort_s_drive", 32'(s), 32'd1);
    check("abort_count_pre", 32'(count), 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_s", 32'(s), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    sb.delete();
    p0 = pulses;
    tick();
    rstn = 1'b1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_pulses", 32'(pulses - p0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // Push and pop together at count 2, then wrap-around order over 10 commands.
    p0 = pulses;
    send(ops38[0]);
    check("pp_count0", 32'(count), 32'd1);
    send(ops38[1]);
    check("pp_count1", 32'(count), 32'd1);
    send(ops38[2]);
    check("pp_count2", 32'(count), 32'd2);
    tick();
    check("pp_count3", 32'(count), 32'd2);
    send(ops38[3]);
    check("pp_count_pushpop", 32'(count), 32'd2);
    for (int i = 4; i < 10; i++) send(ops38[i]);
    wait_idle();
    tick();
    check("wrap_pulses", 32'(pulses - p0), 32'd10);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);
    check("wrap_mismatch", 32'(mismatch), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
